seg7_driver: RTL and testbench

Memory-mapped eight-digit seven-segment display controller sitting downstream of the CPU's IO write path, beside the LED and switch ports. The CPU writes 32 bits of hex display data and an enable mask with `sw` to the segment IO window. The block latches them and time-multiplexes the eight common-anode digits with a free-running scan counter. Segment and digit-enable outputs are registered and drive board pins directly.

---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/seg7_driver_if.sv | 26 ++
 rtl/hex_to_seg7.sv | 33 +++
 rtl/seg7_driver.sv | 110 +++++++++++
 tb/tb_seg7_driver.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display controller: active-low
// segment patterns {dp,g,f,e,d,c,b,a}, IO window sub-addresses and digit count.
package seg7_pkg;

  // Number of scanned digits on this board.
  localparam int SEG_DIGITS = 8;
  localparam int SEG_IDX_W  = $clog2(SEG_DIGITS);

  // Sub-addresses inside the segment IO window; every other value hits the mask.
  localparam logic [1:0] SEG_ADDR_LO = 2'b00;
  localparam logic [1:0] SEG_ADDR_HI = 2'b10;

  // Active-low hex glyphs, decimal point always off (bit 7 high).
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low one-hot digit enable for the given scan index.
  function automatic logic [SEG_DIGITS-1:0] digit_sel_n(input logic [SEG_IDX_W-1:0] idx);
    logic [SEG_DIGITS-1:0] onehot;
    onehot = '0;
    onehot[idx] = 1'b1;
    return ~onehot;
  endfunction

endpackage

// File: rtl/seg7_driver_if.sv
// CPU IO write path into the segment window: decode select, write strobe,
// low address bits and the lower half of the store data.
interface seg7_driver_if;

  logic        SegCtrl;
  logic        ioWrite;
  logic [1:0]  segAddr;
  logic [15:0] write_data;

  // CPU / memory-IO side drives the write.
  modport master (
    output SegCtrl,
    output ioWrite,
    output segAddr,
    output write_data
  );

  // Display controller only ever listens; there is no read-back path.
  modport slave (
    input SegCtrl,
    input ioWrite,
    input segAddr,
    input write_data
  );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph, dp off.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  // Glyph lookup for all sixteen hex values.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_driver.sv
// Eight-digit common-anode seven-segment controller on the CPU IO write path.
// Latches 32 bits of hex data plus an enable mask and scans one digit at a
// time; segment and digit-enable pins come straight from registers.
module seg7_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 20000,  // cycles each digit stays lit, 2..2^20
  parameter int DIGITS   = 8       // fixed by the board
) (
  input  logic              clock,
  input  logic              reset,  // synchronous, active-low
  seg7_driver_if.slave      bus,
  output logic [DIGITS-1:0] seg_en,
  output logic [7:0]        seg_out
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  // Written registers.
  logic [15:0]           data_lo_q, data_lo_d;
  logic [15:0]           data_hi_q, data_hi_d;
  logic [DIGITS-1:0]     mask_q,    mask_d;

  // Scan state.
  logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
  logic [SEG_IDX_W-1:0]  digit_idx_q, digit_idx_d;

  // Pin registers.
  logic [DIGITS-1:0]     seg_en_q,  seg_en_d;
  logic [7:0]            seg_out_q, seg_out_d;

  logic                  wr_en;
  logic [SEG_DIGITS*4-1:0] data_all;
  logic [3:0]            nibble;
  logic [7:0]            glyph;

  assign wr_en    = bus.SegCtrl & bus.ioWrite;
  assign data_all = {data_hi_q, data_lo_q};

  // Write decode: each access replaces one whole register, so a scan never sees half a write.
  always_comb begin
    data_lo_d = data_lo_q;
    data_hi_d = data_hi_q;
    mask_d    = mask_q;
    if (wr_en) begin
      case (bus.segAddr)
        SEG_ADDR_LO: data_lo_d = bus.write_data;
        SEG_ADDR_HI: data_hi_d = bus.write_data;
        default:     mask_d    = bus.write_data[DIGITS-1:0];
      endcase
    end
  end

  // Free-running scan divider; the digit index advances on each divider wrap.
  always_comb begin
    div_cnt_d   = div_cnt_q + CNT_W'(1);
    digit_idx_d = digit_idx_q;
    if (div_cnt_q == CNT_LAST) begin
      div_cnt_d   = '0;
      digit_idx_d = digit_idx_q + SEG_IDX_W'(1);
    end
  end

  // Nibble of the digit currently being scanned.
  always_comb begin
    nibble = data_all[{digit_idx_q, 2'b00} +: 4];
  end

  hex_to_seg7 u_hex (
    .nibble (nibble),
    .seg    (glyph)
  );

  // Output pattern for the scanned digit; a masked digit stays fully dark.
  always_comb begin
    seg_en_d  = {DIGITS{1'b1}};
    seg_out_d = SEG_BLANK;
    if (mask_q[digit_idx_q]) begin
      seg_en_d  = digit_sel_n(digit_idx_q);
      seg_out_d = glyph;
    end
  end

  // State update; reset wins over any write or scan activity in the same cycle.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments make every flop sample the pre-edge values, avoiding ordering races.
    if (!reset) begin
      data_lo_q   <= '0;
      data_hi_q   <= '0;
      mask_q      <= {DIGITS{1'b1}};
      div_cnt_q   <= '0;
      digit_idx_q <= '0;
      seg_en_q    <= {DIGITS{1'b1}};
      seg_out_q   <= SEG_BLANK;
    end else begin
      data_lo_q   <= data_lo_d;
      data_hi_q   <= data_hi_d;
      mask_q      <= mask_d;
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      seg_en_q    <= seg_en_d;
      seg_out_q   <= seg_out_d;
    end
  end

  assign seg_en  = seg_en_q;
  assign seg_out = seg_out_q;

endmodule

// File: tb/tb_seg7_driver.sv
// Scoreboard bench for seg7_driver with SCAN_DIV=4. Stimulus pushes
// hand-computed pin values tagged with the clock edge they must follow; a
// monitor pops and compares them on the falling edge after that rising edge.
module tb_seg7_driver;

  localparam int SCAN_DIV = 4;

  logic       clock;
  logic       reset;
  logic [7:0] seg_en;
  logic [7:0] seg_out;
  int         cyc;
  int         total;
  int         bad;

  seg7_driver_if bus ();

  seg7_driver #(
    .SCAN_DIV (SCAN_DIV),
    .DIGITS   (8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .seg_en  (seg_en),
    .seg_out (seg_out)
  );

  typedef struct {
    int         cyc;
    logic [7:0] en;
    logic [7:0] out;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Active-low digit enables by digit number.
  logic [7:0] en_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compare every expectation due at this edge.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      total++;
      if (mon_e.cyc != cyc) begin
        bad++;
        $display("FAIL %s: expectation for edge %0d skipped (now %0d)", mon_e.name, mon_e.cyc, cyc);
      end else if (seg_en !== mon_e.en || seg_out !== mon_e.out) begin
        bad++;
        $display("FAIL %s @%0d: seg_en=%h seg_out=%h, want seg_en=%h seg_out=%h",
                 mon_e.name, cyc, seg_en, seg_out, mon_e.en, mon_e.out);
      end
    end
  end

  task automatic expect_at(input int c, input logic [7:0] en, input logic [7:0] out, input string nm);
    exp_t e;
    e.cyc  = c;
    e.en   = en;
    e.out  = out;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Return 1 time unit after rising edge e, so new drives hit edge e+1.
  task automatic wait_edge(input int e);
    while (cyc < e) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Present a bus access so it is sampled exactly at edge w.
  task automatic bus_access(input int w, input logic sel, input logic wr,
                            input logic [1:0] addr, input logic [15:0] data);
    wait_edge(w - 1);
    bus.SegCtrl    = sel;
    bus.ioWrite    = wr;
    bus.segAddr    = addr;
    bus.write_data = data;
    wait_edge(w);
    bus.SegCtrl    = 1'b0;
    bus.ioWrite    = 1'b0;
  endtask

  // Safety net in case the scan never reaches the scheduled edges.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lo_tab [8];
    logic [7:0] hi_tab [8];
    total = 0;
    bad   = 0;
    reset          = 1'b0;
    bus.SegCtrl    = 1'b0;
    bus.ioWrite    = 1'b0;
    bus.segAddr    = 2'b00;
    bus.write_data = 16'h0000;

    // Reset held over edges 1..3; first active edge is 4, digit k owns edges 4+4k..7+4k.
    for (int c = 1; c <= 3; c++) expect_at(c, 8'hFF, 8'hFF, "reset_dark");
    for (int k = 0; k < 8; k++) expect_at(4 + 4 * k, en_tab[k], 8'hC0, "post_reset_zero");
    wait_edge(3);
    reset = 1'b1;

    // Low write 1234 at edge 36, checked one frame later.
    lo_tab = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    for (int k = 0; k < 8; k++) expect_at(69 + 4 * k, en_tab[k], lo_tab[k], "low_write");
    bus_access(36, 1'b1, 1'b1, 2'b00, 16'h1234);

    // High write ABCD at edge 100, then wrap back to digit 0.
    hi_tab = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hA1, 8'hC6, 8'h83, 8'h88};
    for (int k = 0; k < 8; k++) expect_at(134 + 4 * k, en_tab[k], hi_tab[k], "high_write");
    expect_at(164, 8'hFE, 8'h99, "wrap_to_digit0");
    bus_access(100, 1'b1, 1'b1, 2'b10, 16'hABCD);

    // Mask 0005 at edge 196 (upper byte ignored); whole frame 228..259 checked.
    for (int c = 228; c <= 259; c++) begin
      case ((c - 228) / 4)
        0:       expect_at(c, 8'hFE, 8'h99, "mask_digit0");
        2:       expect_at(c, 8'hFB, 8'hA4, "mask_digit2");
        default: expect_at(c, 8'hFF, 8'hFF, "mask_dark");
      endcase
    end
    bus_access(196, 1'b1, 1'b1, 2'b01, 16'hFF05);

    // Gated accesses at edges 260 and 261 must not touch data_lo.
    expect_at(293, 8'hFE, 8'h99, "gate_digit0");
    expect_at(301, 8'hFB, 8'hA4, "gate_digit2");
    bus_access(260, 1'b0, 1'b1, 2'b00, 16'hFFFF);
    bus_access(261, 1'b1, 1'b0, 2'b00, 16'hFFFF);

    // Write 0F34 on the wrap edge 331 (digit 1 -> 2): digit 2 shows F at once, no glitch.
    expect_at(327, 8'hFE, 8'h99, "wrap_prev_digit0");
    expect_at(330, 8'hFF, 8'hFF, "wrap_masked1");
    expect_at(331, 8'hFF, 8'hFF, "wrap_edge_out");
    for (int c = 332; c <= 335; c++) expect_at(c, 8'hFB, 8'h8E, "wrap_new_nibble");
    expect_at(356, 8'hFE, 8'h99, "wrap_digit0_kept");
    bus_access(331, 1'b1, 1'b1, 2'b00, 16'h0F34);

    // Reset at edge 366 together with a write of FFFF; write must be lost.
    expect_at(365, 8'hFB, 8'h8E, "pre_reset");
    expect_at(366, 8'hFF, 8'hFF, "mid_reset_dark");
    expect_at(367, 8'hFE, 8'hC0, "rst_write_dropped");
    expect_at(368, 8'hFE, 8'hC0, "rst_digit0_hold");
    expect_at(371, 8'hFD, 8'hC0, "rst_digit1");
    expect_at(383, 8'hEF, 8'hC0, "rst_hi_cleared");
    wait_edge(365);
    reset          = 1'b0;
    bus.SegCtrl    = 1'b1;
    bus.ioWrite    = 1'b1;
    bus.segAddr    = 2'b00;
    bus.write_data = 16'hFFFF;
    wait_edge(366);
    reset       = 1'b1;
    bus.SegCtrl = 1'b0;
    bus.ioWrite = 1'b0;

    wait_edge(390);
    @(negedge clock);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
